// File: rtl/mont_issue_pkg.sv
// Shared types for the Montgomery multiplier issuer: FSM state encoding and
// the sizing helper for the optional WAIT timeout counter.
package mont_issue_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // The WAIT counter only has to reach cycles-1, so ceil(log2(cycles)) bits suffice.
  function automatic int tmo_cnt_w(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/mont_mul_issuer.sv
// Job issuer for the Montgomery multiplier core: accepts {a,b} requests, pulses the core,
// captures y and returns it on a valid/ready response port. MONT_ISSUE_TIMEOUT_EN adds a WAIT timeout.
module mont_mul_issuer
  import mont_issue_pkg::*;
#(
  parameter int NBITS = 4096,
  parameter int CNT_W = 32
`ifdef MONT_ISSUE_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [NBITS-1:0] cfg_m,
  input  logic [NBITS-1:0] cfg_m_inv,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [NBITS-1:0] req_a,
  input  logic [NBITS-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [NBITS-1:0] rsp_y,
  output logic             rsp_timeout,
  output logic             mm_enable_p,
  output logic [NBITS-1:0] mm_a,
  output logic [NBITS-1:0] mm_b,
  output logic [NBITS-1:0] mm_m,
  output logic [NBITS-1:0] mm_m_inv,
  input  logic [NBITS-1:0] mm_y,
  input  logic             mm_done_irq_p,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  state_t state;

`ifdef MONT_ISSUE_TIMEOUT_EN
  localparam int TW = tmo_cnt_w(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] wait_cnt;
  logic          timeout_q;

  assign rsp_timeout = timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_y       <= '0;
      mm_enable_p <= 1'b0;
      mm_a        <= '0;
      mm_b        <= '0;
      mm_m        <= '0;
      mm_m_inv    <= '0;
      busy        <= 1'b0;
      op_count    <= '0;
`ifdef MONT_ISSUE_TIMEOUT_EN
      wait_cnt    <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      mm_enable_p <= 1'b0;
      unique case (state)
        IDLE: begin
          // Config is written before the operands so a same-cycle job sees the new m / m_inv.
          if (cfg_we) begin
            mm_m     <= cfg_m;
            mm_m_inv <= cfg_m_inv;
          end
          // NOTE: req_ready is a register that is still 0 on the first cycle out of reset,
          // so the handshake must use it rather than assume IDLE implies ready.
          if (req_valid && req_ready) begin
            mm_a        <= req_a;
            mm_b        <= req_b;
            mm_enable_p <= 1'b1;
            req_ready   <= 1'b0;
            busy        <= 1'b1;
            state       <= ISSUE;
          end else begin
            req_ready <= 1'b1;
          end
        end
        ISSUE: begin
`ifdef MONT_ISSUE_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (mm_done_irq_p) begin
            rsp_y     <= mm_y;
            rsp_valid <= 1'b1;
`ifdef MONT_ISSUE_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            state     <= RESP;
          end
`ifdef MONT_ISSUE_TIMEOUT_EN
          else if (wait_cnt == WAIT_LAST) begin
            rsp_y     <= '0;
            rsp_valid <= 1'b1;
            timeout_q <= 1'b1;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            op_count  <= op_count + CNT_W'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_mul_issuer.sv
// Self-checking bench for mont_mul_issuer: directed and randomized jobs against a simple
// job-level model of the issuer's externally visible behaviour.
module tb_mont_mul_issuer;

  localparam int NBITS = 8;
  localparam int CNT_W = 4;
`ifdef MONT_ISSUE_TIMEOUT_EN
  localparam int TMO = 16;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_we;
  logic [NBITS-1:0] cfg_m, cfg_m_inv;
  logic             req_valid, req_ready;
  logic [NBITS-1:0] req_a, req_b;
  logic             rsp_valid, rsp_ready;
  logic [NBITS-1:0] rsp_y;
  logic             rsp_timeout;
  logic             mm_enable_p;
  logic [NBITS-1:0] mm_a, mm_b, mm_m, mm_m_inv, mm_y;
  logic             mm_done_irq_p;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  mont_mul_issuer #(
    .NBITS(NBITS),
    .CNT_W(CNT_W)
`ifdef MONT_ISSUE_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(TMO)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_we       (cfg_we),
    .cfg_m        (cfg_m),
    .cfg_m_inv    (cfg_m_inv),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_y        (rsp_y),
    .rsp_timeout  (rsp_timeout),
    .mm_enable_p  (mm_enable_p),
    .mm_a         (mm_a),
    .mm_b         (mm_b),
    .mm_m         (mm_m),
    .mm_m_inv     (mm_m_inv),
    .mm_y         (mm_y),
    .mm_done_irq_p(mm_done_irq_p),
    .busy         (busy),
    .op_count     (op_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int en_cnt   = 0;

  // Model state: config registers and number of completed jobs since reset.
  logic [NBITS-1:0] exp_m    = '0;
  logic [NBITS-1:0] exp_minv = '0;
  int               exp_cnt  = 0;

  // Start pulses seen by the core (sampled before the edge updates them).
  always @(posedge clk) if (mm_enable_p === 1'b1) en_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [63:0] exp_count();
    return 64'(exp_cnt % (1 << CNT_W));
  endfunction

  task automatic cfg_write(input logic [NBITS-1:0] m, input logic [NBITS-1:0] minv);
    cfg_we = 1'b1; cfg_m = m; cfg_m_inv = minv;
    tick();
    cfg_we = 1'b0;
    exp_m = m; exp_minv = minv;
    check("cfg_idle_m", mm_m, exp_m);
    check("cfg_idle_minv", mm_m_inv, exp_minv);
  endtask

  // Accept a job; returns at the negedge inside the ISSUE cycle.
  task automatic accept(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b, input bit cfg_now);
    check("idle_req_ready", req_ready, 1);
    req_valid = 1'b1; req_a = a; req_b = b;
    if (cfg_now) begin
      cfg_we = 1'b1; cfg_m = 8'($urandom); cfg_m_inv = 8'($urandom);
      exp_m = cfg_m; exp_minv = cfg_m_inv;
    end
    tick();
    req_valid = 1'b0; cfg_we = 1'b0;
    check("issue_enable", mm_enable_p, 1);
    check("issue_a", mm_a, a);
    check("issue_b", mm_b, b);
    check("issue_m", mm_m, exp_m);
    check("issue_minv", mm_m_inv, exp_minv);
    check("issue_busy", busy, 1);
    check("issue_req_ready", req_ready, 0);
  endtask

  // Consume the response and check the return to IDLE.
  task automatic finish_rsp(input int en0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_cnt++;
    check("done_rsp_valid", rsp_valid, 0);
    check("done_busy", busy, 0);
    check("done_req_ready", req_ready, 1);
    check("done_op_count", op_count, exp_count());
    check("one_enable_pulse", 64'(en_cnt - en0), 1);
  endtask

  task automatic run_job(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b,
                         input logic [NBITS-1:0] y, input int delay, input int hold,
                         input bit cfg_now, input bit spurious, input bit cfg_in_wait);
    int en0;
    en0 = en_cnt;
    accept(a, b, cfg_now);
    if (spurious) begin
      mm_done_irq_p = 1'b1; mm_y = ~y;
    end
    tick();
    mm_done_irq_p = 1'b0;
    check("wait_enable_low", mm_enable_p, 0);
    check("wait_no_rsp", rsp_valid, 0);
    if (cfg_in_wait) begin
      cfg_we = 1'b1; cfg_m = 8'h0F; cfg_m_inv = 8'h0F;
    end
    for (int i = 2; i < delay; i++) begin
      tick();
      cfg_we = 1'b0;
      check("wait_no_rsp", rsp_valid, 0);
      check("wait_cfg_held", mm_m, exp_m);
    end
    mm_done_irq_p = 1'b1; mm_y = y;
    tick();
    mm_done_irq_p = 1'b0; cfg_we = 1'b0;
    check("rsp_valid", rsp_valid, 1);
    check("rsp_y", rsp_y, y);
    check("rsp_timeout", rsp_timeout, 0);
    check("rsp_cfg_held", mm_m, exp_m);
    // Backpressure: a new request and a stray done pulse must both be ignored.
    req_valid = 1'b1; req_a = ~a; req_b = ~b;
    for (int i = 0; i < hold; i++) begin
      if (i == 0) begin
        mm_done_irq_p = 1'b1; mm_y = ~y;
      end
      tick();
      mm_done_irq_p = 1'b0;
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_y", rsp_y, y);
      check("hold_req_ready", req_ready, 0);
      check("hold_mm_a", mm_a, a);
    end
    req_valid = 1'b0;
    finish_rsp(en0);
  endtask

`ifdef MONT_ISSUE_TIMEOUT_EN
  task automatic run_timeout(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b,
                             input bit done_at_expiry, input logic [NBITS-1:0] y);
    int en0;
    en0 = en_cnt;
    accept(a, b, 1'b0);
    for (int i = 0; i < TMO; i++) begin
      tick();
      check("tmo_wait_no_rsp", rsp_valid, 0);
    end
    if (done_at_expiry) begin
      mm_done_irq_p = 1'b1; mm_y = y;
    end
    tick();
    mm_done_irq_p = 1'b0;
    check("tmo_rsp_valid", rsp_valid, 1);
    check("tmo_rsp_y", rsp_y, done_at_expiry ? y : 8'h00);
    check("tmo_flag", rsp_timeout, done_at_expiry ? 1'b0 : 1'b1);
    finish_rsp(en0);
  endtask
`endif

  initial begin
    logic [NBITS-1:0] keep_y;
    rst = 1'b1; cfg_we = 1'b0; cfg_m = '0; cfg_m_inv = '0;
    req_valid = 1'b0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    mm_y = '0; mm_done_irq_p = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick();
    check("post_rst_req_ready", req_ready, 1);
    check("post_rst_rsp_valid", rsp_valid, 0);
    check("post_rst_op_count", op_count, 0);
    check("post_rst_mm_m", mm_m, 0);
    check("post_rst_enable", mm_enable_p, 0);
    check("post_rst_timeout", rsp_timeout, 0);

    // Basic job with 10 cycles of backpressure and a config write dropped during WAIT
    cfg_write(8'hFF, 8'h01);
    run_job(8'hFE, 8'hFC, 8'h12, 5, 10, 1'b0, 1'b0, 1'b1);
    check("job1_rsp_y_kept", rsp_y, 8'h12);

    // Same config write in IDLE takes effect
    cfg_write(8'h0F, 8'h0F);

    // Spurious done in IDLE
    mm_done_irq_p = 1'b1; mm_y = 8'hAA;
    tick();
    mm_done_irq_p = 1'b0;
    tick();
    check("spur_idle_rsp_valid", rsp_valid, 0);
    check("spur_idle_busy", busy, 0);
    check("spur_idle_op_count", op_count, exp_count());
    check("spur_idle_rsp_y", rsp_y, 8'h12);

    // Randomized jobs; enough of them to wrap the 4-bit op_count
    for (int j = 0; j < 18; j++) begin
      run_job(8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(2, 7)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

`ifdef MONT_ISSUE_TIMEOUT_EN
    run_timeout(8'h33, 8'h44, 1'b0, 8'h00);
    run_timeout(8'h55, 8'h66, 1'b1, 8'h9C);
`endif

    // Reset in the middle of WAIT, followed by a late done pulse
    cfg_write(8'hC3, 8'h3C);
    accept(8'h77, 8'h88, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    check("midrst_req_ready", req_ready, 0);
    rst = 1'b0;
    exp_cnt = 0; exp_m = '0; exp_minv = '0;
    mm_done_irq_p = 1'b1; mm_y = 8'h55;
    tick();
    mm_done_irq_p = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_op_count", op_count, exp_count());
    check("midrst_mm_m", mm_m, exp_m);
    check("midrst_mm_a", mm_a, 0);
    check("midrst_rsp_y", rsp_y, 0);
    check("midrst_req_ready", req_ready, 1);

    // Recovery with cleared config
    keep_y = 8'($urandom);
    run_job(8'h01, 8'h02, keep_y, 3, 1, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
